// File: rtl/rv32i_fetch_unit.sv
// rv32i_fetch_unit
//   Instruction fetch stage. Takes the next PC from writeback, issues a
//   strobe/ack read on the instruction bus and hands the fetched word plus its
//   PC to decode under an o_ce / i_stall handshake. Misaligned PCs and bus
//   timeouts are delivered as flagged NOPs instead of real instructions.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_pc_next/valid     next PC from writeback (valid is a 1-cycle pulse)
//   o_inst_stb/addr     instruction bus read request and word address
//   i_inst_ack/i_inst   bus acknowledge with read data in the same cycle
//   o_inst/o_pc         instruction and its PC presented to decode
//   o_exc_misaligned    o_pc[1:0] != 0, o_inst is a NOP
//   o_fetch_err         bus timeout, o_inst is a NOP
//   o_ce                decode outputs valid
//   i_stall             decode cannot accept; outputs are held
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a PC source (boot, i_pc_valid or pending PC)
// WAIT_ACK | bus request outstanding; timeout down-counter running
// DELIVER  | o_ce high, outputs held until decode accepts (i_stall=0)

module rv32i_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          MAX_WAIT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc_next,
    input  logic        i_pc_valid,
    output logic        o_inst_stb,
    output logic [31:0] o_inst_addr,
    input  logic        i_inst_ack,
    input  logic [31:0] i_inst,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_exc_misaligned,
    output logic        o_fetch_err,
    output logic        o_ce,
    input  logic        i_stall
);

    localparam int              CW        = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]   WAIT_LOAD = CW'(MAX_WAIT - 1);
    localparam logic [31:0]     NOP       = 32'h0000_0013;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_ACK = 2'd1;
    localparam logic [1:0] S_DELIVER  = 2'd2;

    logic [1:0]    state;
    logic          boot;
    logic          pend_v;
    logic [31:0]   pend_pc;
    logic [CW-1:0] wait_cnt;

    logic          do_launch;
    logic [31:0]   launch_addr;

    // Boot has priority, then a fresh PC from writeback, then a PC that
    // arrived while the stage was busy.
    always_comb begin
        do_launch   = boot | i_pc_valid | pend_v;
        launch_addr = pend_pc;
        if (boot) begin
            launch_addr = PC_RESET;
        end else if (i_pc_valid) begin
            launch_addr = i_pc_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= S_IDLE;
            boot             <= 1'b1;
            pend_v           <= 1'b0;
            pend_pc          <= 32'h0;
            wait_cnt         <= '0;
            o_inst_stb       <= 1'b0;
            o_inst_addr      <= PC_RESET;
            o_inst           <= 32'h0;
            o_pc             <= PC_RESET;
            o_exc_misaligned <= 1'b0;
            o_fetch_err      <= 1'b0;
            o_ce             <= 1'b0;
        end else begin
            // Redirects arriving while busy are parked; the latest one wins.
            if (i_pc_valid && state != S_IDLE) begin
                pend_pc <= i_pc_next;
                pend_v  <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (do_launch) begin
                        boot        <= 1'b0;
                        pend_v      <= 1'b0;
                        o_pc        <= launch_addr;
                        o_inst_addr <= launch_addr;
                        if (launch_addr[1:0] != 2'b00) begin
                            o_inst           <= NOP;
                            o_exc_misaligned <= 1'b1;
                            o_ce             <= 1'b1;
                            state            <= S_DELIVER;
                        end else begin
                            o_inst_stb <= 1'b1;
                            wait_cnt   <= WAIT_LOAD;
                            state      <= S_WAIT_ACK;
                        end
                    end
                end

                S_WAIT_ACK: begin
                    // An ack in the terminal cycle still counts as a hit.
                    if (i_inst_ack) begin
                        o_inst     <= i_inst;
                        o_inst_stb <= 1'b0;
                        o_ce       <= 1'b1;
                        state      <= S_DELIVER;
                    end else if (wait_cnt == '0) begin
                        o_inst_stb  <= 1'b0;
                        o_inst      <= NOP;
                        o_fetch_err <= 1'b1;
                        o_ce        <= 1'b1;
                        state       <= S_DELIVER;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end

                S_DELIVER: begin
                    if (!i_stall) begin
                        o_ce             <= 1'b0;
                        o_exc_misaligned <= 1'b0;
                        o_fetch_err      <= 1'b0;
                        state            <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
module tb_rv32i_fetch_unit;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_pc_next = 32'h0;
    logic        i_pc_valid = 1'b0;
    logic        o_inst_stb;
    logic [31:0] o_inst_addr;
    logic        i_inst_ack = 1'b0;
    logic [31:0] i_inst = 32'h0;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        o_exc_misaligned;
    logic        o_fetch_err;
    logic        o_ce;
    logic        i_stall = 1'b0;

    int checks = 0;
    int errors = 0;

    rv32i_fetch_unit #(
        .PC_RESET (32'h0000_0000),
        .MAX_WAIT (8)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_pc_next        (i_pc_next),
        .i_pc_valid       (i_pc_valid),
        .o_inst_stb       (o_inst_stb),
        .o_inst_addr      (o_inst_addr),
        .i_inst_ack       (i_inst_ack),
        .i_inst           (i_inst),
        .o_inst           (o_inst),
        .o_pc             (o_pc),
        .o_exc_misaligned (o_exc_misaligned),
        .o_fetch_err      (o_fetch_err),
        .o_ce             (o_ce),
        .i_stall          (i_stall)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        pv;
        logic [31:0] pcn;
        logic        ack;
        logic [31:0] inst;
        logic        stall;
        logic        e_stb;
        logic [31:0] e_addr;
        logic        e_ce;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_mis;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic pv, logic [31:0] pcn, logic ack, logic [31:0] inst,
                                logic stall, logic e_stb, logic [31:0] e_addr, logic e_ce,
                                logic [31:0] e_inst, logic [31:0] e_pc, logic e_mis,
                                logic e_err);
        vec_t v;
        v.pv = pv; v.pcn = pcn; v.ack = ack; v.inst = inst; v.stall = stall;
        v.e_stb = e_stb; v.e_addr = e_addr; v.e_ce = e_ce; v.e_inst = e_inst;
        v.e_pc = e_pc; v.e_mis = e_mis; v.e_err = e_err;
        return v;
    endfunction

    // Apply inputs for one cycle, then sample 1 time unit after the edge.
    task automatic step(input logic rst, input logic pv, input logic [31:0] pcn,
                        input logic ack, input logic [31:0] inst, input logic stall);
        i_rst      = rst;
        i_pc_valid = pv;
        i_pc_next  = pcn;
        i_inst_ack = ack;
        i_inst     = inst;
        i_stall    = stall;
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic stb, input logic [31:0] addr,
                       input logic ce, input logic [31:0] inst, input logic [31:0] pc,
                       input logic mis, input logic err);
        checks++;
        if (o_inst_stb !== stb || o_inst_addr !== addr || o_ce !== ce ||
            o_inst !== inst || o_pc !== pc || o_exc_misaligned !== mis ||
            o_fetch_err !== err) begin
            errors++;
            $display("FAIL %s: got stb=%b addr=%h ce=%b inst=%h pc=%h mis=%b err=%b want stb=%b addr=%h ce=%b inst=%h pc=%h mis=%b err=%b",
                     nm, o_inst_stb, o_inst_addr, o_ce, o_inst, o_pc, o_exc_misaligned,
                     o_fetch_err, stb, addr, ce, inst, pc, mis, err);
        end
    endtask

    initial begin
        // boot fetch of PC 0, ack one cycle after stb rises
        vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1, 32'h0,   0, 32'h0,        32'h0,   0, 0));
        vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 1, 32'h0,   0, 32'h0,        32'h0,   0, 0));
        vecs.push_back(mk(0, 32'h0,   1, 32'h00500093, 0, 0, 32'h0,   1, 32'h00500093, 32'h0,   0, 0));
        vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 0, 32'h0,   0, 32'h00500093, 32'h0,   0, 0));
        // 0x104 with three wait cycles
        vecs.push_back(mk(1, 32'h104, 0, 32'h0,        0, 1, 32'h104, 0, 32'h00500093, 32'h104, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 32'h0, 0, 32'h0,      0, 1, 32'h104, 0, 32'h00500093, 32'h104, 0, 0));
        vecs.push_back(mk(0, 32'h0,   1, 32'h00A00113, 0, 0, 32'h104, 1, 32'h00A00113, 32'h104, 0, 0));
        vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 0, 32'h104, 0, 32'h00A00113, 32'h104, 0, 0));
        // misaligned 0x102: no bus cycle, flagged NOP, held under stall
        vecs.push_back(mk(1, 32'h102, 0, 32'h0,        0, 0, 32'h102, 1, 32'h13,       32'h102, 1, 0));
        vecs.push_back(mk(0, 32'h0,   0, 32'h0,        1, 0, 32'h102, 1, 32'h13,       32'h102, 1, 0));
        vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 0, 32'h102, 0, 32'h13,       32'h102, 0, 0));
        // timeout with MAX_WAIT=8: stb high for 8 cycles
        vecs.push_back(mk(1, 32'h108, 0, 32'h0,        0, 1, 32'h108, 0, 32'h13,       32'h108, 0, 0));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(0, 32'h0, 0, 32'h0,      0, 1, 32'h108, 0, 32'h13,       32'h108, 0, 0));
        vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 0, 32'h108, 1, 32'h13,       32'h108, 0, 1));
        // late ack ignored in DELIVER and in IDLE
        vecs.push_back(mk(0, 32'h0,   1, 32'hDEADBEEF, 1, 0, 32'h108, 1, 32'h13,       32'h108, 0, 1));
        vecs.push_back(mk(0, 32'h0,   1, 32'hDEADBEEF, 0, 0, 32'h108, 0, 32'h13,       32'h108, 0, 0));
        vecs.push_back(mk(0, 32'h0,   1, 32'hDEADBEEF, 0, 0, 32'h108, 0, 32'h13,       32'h108, 0, 0));
        // zero-wait bus: pc_valid -> o_ce in 2 cycles
        vecs.push_back(mk(1, 32'h10C, 0, 32'h0,        0, 1, 32'h10C, 0, 32'h13,       32'h10C, 0, 0));
        vecs.push_back(mk(0, 32'h0,   1, 32'h11111111, 0, 0, 32'h10C, 1, 32'h11111111, 32'h10C, 0, 0));
        vecs.push_back(mk(0, 32'h0,   0, 32'h0,        0, 0, 32'h10C, 0, 32'h11111111, 32'h10C, 0, 0));

        step(1, 0, 32'h0, 0, 32'h0, 0);
        step(1, 0, 32'h0, 0, 32'h0, 0);
        chk("reset", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);

        foreach (vecs[k]) begin
            step(0, vecs[k].pv, vecs[k].pcn, vecs[k].ack, vecs[k].inst, vecs[k].stall);
            chk($sformatf("vec%0d", k), vecs[k].e_stb, vecs[k].e_addr, vecs[k].e_ce,
                vecs[k].e_inst, vecs[k].e_pc, vecs[k].e_mis, vecs[k].e_err);
        end

        // stall in DELIVER with two redirects: last one (0x300) is fetched next
        step(0, 1, 32'h110, 0, 32'h0, 0);
        chk("s5_launch", 1, 32'h110, 0, 32'h11111111, 32'h110, 0, 0);
        step(0, 0, 32'h0, 1, 32'h22222222, 0);
        chk("s5_ack", 0, 32'h110, 1, 32'h22222222, 32'h110, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, (i == 1) || (i == 3), (i == 1) ? 32'h200 : 32'h300, 0, 32'h0, 1);
            chk($sformatf("s5_frozen%0d", i), 0, 32'h110, 1, 32'h22222222, 32'h110, 0, 0);
        end
        step(0, 0, 32'h0, 0, 32'h0, 0);
        chk("s5_release", 0, 32'h110, 0, 32'h22222222, 32'h110, 0, 0);
        step(0, 0, 32'h0, 0, 32'h0, 0);
        chk("s5_pend_fetch", 1, 32'h300, 0, 32'h22222222, 32'h300, 0, 0);
        step(0, 0, 32'h0, 1, 32'h33333333, 0);
        chk("s5_pend_ack", 0, 32'h300, 1, 32'h33333333, 32'h300, 0, 0);

        // pending PC in IDLE loses to a simultaneous i_pc_valid and is dropped
        step(0, 1, 32'h500, 0, 32'h0, 1);
        chk("pw_park", 0, 32'h300, 1, 32'h33333333, 32'h300, 0, 0);
        step(0, 0, 32'h0, 0, 32'h0, 0);
        chk("pw_release", 0, 32'h300, 0, 32'h33333333, 32'h300, 0, 0);
        step(0, 1, 32'h400, 0, 32'h0, 0);
        chk("pw_new_wins", 1, 32'h400, 0, 32'h33333333, 32'h400, 0, 0);
        step(0, 0, 32'h0, 1, 32'h44444444, 0);
        chk("pw_ack", 0, 32'h400, 1, 32'h44444444, 32'h400, 0, 0);
        step(0, 0, 32'h0, 0, 32'h0, 0);
        chk("pw_done", 0, 32'h400, 0, 32'h44444444, 32'h400, 0, 0);
        step(0, 0, 32'h0, 0, 32'h0, 0);
        chk("pw_no_refetch", 0, 32'h400, 0, 32'h44444444, 32'h400, 0, 0);

        // reset in the middle of WAIT_ACK
        step(0, 1, 32'h120, 0, 32'h0, 0);
        chk("rst_launch", 1, 32'h120, 0, 32'h44444444, 32'h120, 0, 0);
        step(0, 0, 32'h0, 0, 32'h0, 0);
        chk("rst_wait", 1, 32'h120, 0, 32'h44444444, 32'h120, 0, 0);
        step(1, 0, 32'h0, 0, 32'h0, 0);
        chk("rst_abort", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 32'h0, 0);
        chk("rst_refetch", 1, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 1, 32'h55555555, 0);
        chk("rst_ack", 0, 32'h0, 1, 32'h55555555, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 32'h0, 0);
        chk("rst_done", 0, 32'h0, 0, 32'h55555555, 32'h0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
